// File: rtl/stopwatch_pkg.sv
// stopwatch_pkg: FSM state encodings and BCD digit limit shared by the stopwatch blocks
package stopwatch_pkg;
   typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, STOP = 2'd2} state_t;
   localparam logic [3:0] BCD_MAX = 4'd9;
endpackage

// File: rtl/bcd_digit_counter.sv
// bcd_digit_counter: one decade 0..9; carry flags the digit at 9 so the next decade can ripple
module bcd_digit_counter
   import stopwatch_pkg::*;
(
   input  logic       Clock,
   input  logic       Reset_n,
   input  logic       inc,
   input  logic       clear,
   output logic [3:0] digit,
   output logic       carry
);
   logic [3:0] digit_q, digit_d;
   always_comb begin
      carry   = digit_q == BCD_MAX;
      digit_d = clear ? 4'd0 : !inc ? digit_q : carry ? 4'd0 : digit_q + 4'd1;
   end
   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) digit_q <= '0;
      else digit_q <= digit_d;
   assign digit = digit_q;
endmodule

// File: rtl/stopwatch_bcd.sv
// stopwatch_bcd: push-button BCD stopwatch with prescaler, lap freeze and sticky full-scale flag
module stopwatch_bcd
   import stopwatch_pkg::*;
#(
   parameter int CLK_DIV = 50000,
   parameter int DIGITS  = 6,
   parameter bit WRAP    = 1'b0
) (
   input  logic                Clock,
   input  logic                Reset_n,
   input  logic                start_n,
   input  logic                stop_n,
   input  logic                lap_n,
   input  logic                clear_n,
   output logic [4*DIGITS-1:0] bcd_out,
   output logic                running,
   output logic                lap_hold,
   output logic                overflow
);
   localparam int PW = $clog2(CLK_DIV);
   localparam logic [PW-1:0] PRE_MAX = PW'(CLK_DIV - 1);
   state_t state_q, state_d;
   logic [3:0] s1_q, s2_q, s3_q, press;
   logic start_p, stop_p, lap_p, clear_p, tick, full, sat, clr;
   logic [PW-1:0] pre_q, pre_d;
   logic [DIGITS-1:0] inc, carry;
   logic [4*DIGITS-1:0] count, cap_q, cap_d;
   logic lap_q, lap_d, ovf_q, ovf_d;
   // bit order {clear, lap, stop, start}; s3 holds the previous synchronised level
   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) begin
         s1_q <= '1;
         s2_q <= '1;
         s3_q <= '1;
      end else begin
         s1_q <= {clear_n, lap_n, stop_n, start_n};
         s2_q <= s1_q;
         s3_q <= s2_q;
      end
   assign press   = s3_q & ~s2_q;
   assign start_p = press[0] & ~press[1];
   assign stop_p  = press[1];
   assign lap_p   = press[2];
   assign clear_p = press[3];
   assign tick = state_q == RUN && pre_q == PRE_MAX;
   assign full = &carry;
   assign sat  = tick && full && !WRAP;
   assign clr  = clear_p && state_q != RUN;
   always_comb begin
      inc[0] = tick && !sat;
      for (int k = 1; k < DIGITS; k++) inc[k] = inc[k-1] && carry[k-1];
   end
   for (genvar i = 0; i < DIGITS; i++) begin : g_digit
      bcd_digit_counter u_digit (
         .Clock   (Clock),
         .Reset_n (Reset_n),
         .inc     (inc[i]),
         .clear   (clr),
         .digit   (count[4*i +: 4]),
         .carry   (carry[i])
      );
   end
   always_ff @(posedge Clock or negedge Reset_n)
      if (!Reset_n) begin
         state_q <= IDLE;
         pre_q   <= '0;
         cap_q   <= '0;
         lap_q   <= 1'b0;
         ovf_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         pre_q   <= pre_d;
         cap_q   <= cap_d;
         lap_q   <= lap_d;
         ovf_q   <= ovf_d;
      end
   always_comb begin
      state_d = state_q == IDLE ? (start_p ? RUN : IDLE) :
                state_q == RUN  ? (stop_p || sat ? STOP : RUN) :
                state_q == STOP ? (clear_p ? IDLE : start_p ? RUN : STOP) : IDLE;
      pre_d = (state_q != RUN || tick) ? '0 : pre_q + PW'(1);
      lap_d = clr ? 1'b0 : !lap_p ? lap_q : state_q == RUN && !lap_q;
      cap_d = clr ? '0 : (lap_p && state_q == RUN && !lap_q) ? count : cap_q;
      ovf_d = !clr && (ovf_q || (tick && full));
   end
   always_comb begin
      running  = state_q == RUN;
      lap_hold = lap_q;
      overflow = ovf_q;
      bcd_out  = lap_q ? cap_q : count;
   end
endmodule
